// File: rtl/csa_sum_divider_if.sv
// Valid/ready bundle between the CSA adder tree, the sum divider and its consumer.
// master drives the dividend/divisor pair and out_ready; slave is the divider.
interface csa_sum_divider_if #(
  parameter int DW = 18,
  parameter int VW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero
  );
endinterface

// File: rtl/csa_sum_divider.sv
// Restoring divider for the CSA tree sum: one quotient bit per clock, valid/ready on both sides.
// Define CSA_DIV_ROUND_EN to add a ROUND cycle that rounds the quotient to nearest (saturating).
module csa_sum_divider #(
  parameter int DW = 18,
  parameter int VW = 8
) (
  input logic               clk,
  input logic               rst,
  csa_sum_divider_if.slave  bus
);

  localparam int CW = $clog2(DW + 1);

`ifdef CSA_DIV_ROUND_EN
  typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`endif

  state_t        state_q, state_d;
  logic [DW-1:0] dvd_q;
  logic [VW-1:0] dvs_q;
  logic [VW:0]   prem_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] quot_q;
  logic [VW-1:0] rem_q;
  logic          dz_q;

  logic [VW+1:0] shifted;
  logic [VW+1:0] trial;
  logic          take;
  logic [VW:0]   r_step;
  logic [DW-1:0] q_step;
  logic          last_iter;

`ifdef CSA_DIV_ROUND_EN
  logic          round_up;
  logic [DW-1:0] q_rnd;
`endif

  // Shifted partial remainder stays below 2*divisor, so bit VW+1 of the
  // difference is a reliable sign bit.
  always_comb begin
    shifted   = {prem_q, dvd_q[DW-1]};
    trial     = shifted - {2'b00, dvs_q};
    take      = ~trial[VW+1];
    r_step    = take ? trial[VW:0] : shifted[VW:0];
    q_step    = {dvd_q[DW-2:0], take};
    last_iter = (cnt_q == CW'(1));
  end

`ifdef CSA_DIV_ROUND_EN
  always_comb begin
    round_up = ({prem_q, 1'b0} >= {2'b00, dvs_q});
    q_rnd    = (round_up && !(&dvd_q)) ? dvd_q + DW'(1) : dvd_q;
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.in_valid) state_d = (bus.divisor == '0) ? DONE : CALC;
`ifdef CSA_DIV_ROUND_EN
      CALC:  if (last_iter) state_d = ROUND;
      ROUND: state_d = DONE;
`else
      CALC:  if (last_iter) state_d = DONE;
`endif
      DONE:  if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            dvd_q  <= bus.dividend;
            dvs_q  <= bus.divisor;
            prem_q <= '0;
            cnt_q  <= CW'(DW);
            dz_q   <= (bus.divisor == '0);
            if (bus.divisor == '0) begin
              quot_q <= '1;
              rem_q  <= '0;
            end
          end
        end
        CALC: begin
          dvd_q  <= q_step;
          prem_q <= r_step;
          cnt_q  <= cnt_q - CW'(1);
`ifndef CSA_DIV_ROUND_EN
          if (last_iter) begin
            quot_q <= q_step;
            rem_q  <= r_step[VW-1:0];
          end
`endif
        end
`ifdef CSA_DIV_ROUND_EN
        ROUND: begin
          quot_q <= q_rnd;
          rem_q  <= prem_q[VW-1:0];
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
  assign bus.div_zero  = dz_q;

endmodule
